alu_issue_stage: RTL and testbench

ID/EX pipeline stage that sits directly upstream of the 64-bit ALU. It registers one decoded instruction using a valid/ready handshake. It resolves operand forwarding from EX/MEM and MEM/WB, and enforces the load-use interlock. It drives the ALU operands `a`, `b` and `ALUOp`, and carries memory/writeback control to EX/MEM.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_issue_stage_if.sv | 73 +++++++
 rtl/alu_issue_stage_fwd_mux.sv | 29 ++
 rtl/alu_issue_stage.sv | 110 +++++++++++
 tb/tb_alu_issue_stage.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage.
// Holds the datapath/index widths, the ALUOp encodings understood by the
// downstream ALU, and the record of fields held between ID and EX.
package alu_pkg;

    localparam int XLEN = 64;   // datapath width
    localparam int REGW = 5;    // register index width
    localparam int OPW  = 4;    // ALUOp width
    localparam int CNTW = 16;   // load-use bubble counter width

    typedef enum logic [OPW-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_NOR = 4'b1100
    } alu_op_e;

    // Everything captured from decode when an instruction is accepted.
    typedef struct packed {
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic            alu_src;
        logic [OPW-1:0]  alu_op;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
    } ex_fields_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bundle of every non-clock/reset signal of alu_issue_stage.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. id_valid/ex_valid never wait on ready; id_ready is combinational
// (it falls during a load-use hazard); ex_valid only changes on a transfer,
// a flush or reset.
// Modports:
//   slave  - the issue stage view (decode inputs in, EX outputs out)
//   master - the environment view (drives decode, forwarding and ex_ready)
interface alu_issue_stage_if;
    import alu_pkg::*;

    // decode side
    logic            id_valid;
    logic            id_ready;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic [REGW-1:0] id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic            id_alu_src;
    logic [OPW-1:0]  id_alu_op;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_mem_to_reg;
    logic            flush;

    // forwarding sources
    logic [REGW-1:0] exmem_rd;
    logic            exmem_reg_write;
    logic [XLEN-1:0] exmem_result;
    logic [REGW-1:0] memwb_rd;
    logic            memwb_reg_write;
    logic [XLEN-1:0] memwb_result;

    // EX side
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [OPW-1:0]  alu_op;
    logic [XLEN-1:0] ex_store_data;
    logic [REGW-1:0] ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_mem_to_reg;
    logic [CNTW-1:0] bubble_cnt;

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_alu_src, id_alu_op, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, flush,
               exmem_rd, exmem_reg_write, exmem_result,
               memwb_rd, memwb_reg_write, memwb_result, ex_ready,
        output id_ready, ex_valid, alu_a, alu_b, alu_op, ex_store_data, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               bubble_cnt
    );

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_alu_src, id_alu_op, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, flush,
               exmem_rd, exmem_reg_write, exmem_result,
               memwb_rd, memwb_reg_write, memwb_result, ex_ready,
        input  id_ready, ex_valid, alu_a, alu_b, alu_op, ex_store_data, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               bubble_cnt
    );

endinterface

// File: rtl/alu_issue_stage_fwd_mux.sv
// Operand forwarding mux for one source register.
// Ports: rs (source index), reg_data (captured register-file value), the
// EX/MEM and MEM/WB destination/write-enable/result triples, and operand.
// EX/MEM is the younger producer so it wins over MEM/WB; x0 is never
// forwarded because it always reads as the captured (zero) value.
module fwd_mux
    import alu_pkg::*;
(
    input  logic [REGW-1:0] rs,
    input  logic [XLEN-1:0] reg_data,
    input  logic [REGW-1:0] exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [REGW-1:0] memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] operand
);

    always_comb begin
        operand = reg_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs)) begin
            operand = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs)) begin
            operand = memwb_result;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage in front of the 64-bit ALU.
// Ports: clk, reset_n (async, active low) and io (alu_issue_stage_if.slave)
// carrying the decode handshake, forwarding sources, EX handshake, ALU
// operands, EX/MEM control and the load-use bubble counter.
// Holds one instruction; inserts exactly one bubble when the held load
// produces a register the incoming instruction reads.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    alu_issue_stage_if.slave  io
);

    logic            v_q, v_d;
    ex_fields_t      f_q, f_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            load_use;
    logic            advance;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    // The held load's result is not available until it reaches MEM/WB, so a
    // consumer arriving right behind it must wait one cycle.
    assign load_use = v_q & f_q.mem_read & (f_q.rd != '0) & io.id_valid &
                      ((f_q.rd == io.id_rs1) | (f_q.rd == io.id_rs2));
    assign advance  = ~v_q | io.ex_ready;

    always_comb begin
        v_d   = v_q;
        f_d   = f_q;
        cnt_d = cnt_q;
        if (io.flush) begin
            v_d = 1'b0;
        end else if (advance) begin
            if (io.id_valid && !load_use) begin
                v_d          = 1'b1;
                f_d.rs1      = io.id_rs1;
                f_d.rs2      = io.id_rs2;
                f_d.rd       = io.id_rd;
                f_d.rs1_data = io.id_rs1_data;
                f_d.rs2_data = io.id_rs2_data;
                f_d.imm      = io.id_imm;
                f_d.alu_src  = io.id_alu_src;
                f_d.alu_op   = io.id_alu_op;
                f_d.reg_write  = io.id_reg_write;
                f_d.mem_read   = io.id_mem_read;
                f_d.mem_write  = io.id_mem_write;
                f_d.mem_to_reg = io.id_mem_to_reg;
            end else begin
                v_d = 1'b0;
                if (load_use && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q   <= 1'b0;
            f_q   <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            f_q   <= f_d;
            cnt_q <= cnt_d;
        end
    end

    fwd_mux u_fwd_rs1 (
        .rs              (f_q.rs1),
        .reg_data        (f_q.rs1_data),
        .exmem_rd        (io.exmem_rd),
        .exmem_reg_write (io.exmem_reg_write),
        .exmem_result    (io.exmem_result),
        .memwb_rd        (io.memwb_rd),
        .memwb_reg_write (io.memwb_reg_write),
        .memwb_result    (io.memwb_result),
        .operand         (fwd_rs1)
    );

    fwd_mux u_fwd_rs2 (
        .rs              (f_q.rs2),
        .reg_data        (f_q.rs2_data),
        .exmem_rd        (io.exmem_rd),
        .exmem_reg_write (io.exmem_reg_write),
        .exmem_result    (io.exmem_result),
        .memwb_rd        (io.memwb_rd),
        .memwb_reg_write (io.memwb_reg_write),
        .memwb_result    (io.memwb_result),
        .operand         (fwd_rs2)
    );

    assign io.id_ready      = advance & ~load_use;
    assign io.ex_valid      = v_q;
    // Operands are not gated: the consumer qualifies them with ex_valid.
    assign io.alu_a         = fwd_rs1;
    assign io.alu_b         = f_q.alu_src ? f_q.imm : fwd_rs2;
    assign io.alu_op        = f_q.alu_op;
    assign io.ex_store_data = fwd_rs2;
    assign io.ex_rd         = f_q.rd;
    // Side-effecting controls are gated so a bubble can never write.
    assign io.ex_reg_write  = v_q & f_q.reg_write;
    assign io.ex_mem_read   = v_q & f_q.mem_read;
    assign io.ex_mem_write  = v_q & f_q.mem_write;
    assign io.ex_mem_to_reg = v_q & f_q.mem_to_reg;
    assign io.bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage: pass-through, immediate select,
// forwarding priority, load-use bubble, backpressure, flush and
// asynchronous reset.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        bus.exmem_rd        = '0;
        bus.exmem_reg_write = 1'b0;
        bus.exmem_result    = '0;
        bus.memwb_rd        = '0;
        bus.memwb_reg_write = 1'b0;
        bus.memwb_result    = '0;
    endtask

    task automatic set_instr(
        input logic [4:0]  rs1, input logic [4:0] rs2, input logic [4:0] rd,
        input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
        input logic        src, input logic [3:0] op,
        input logic        rw, input logic mr, input logic mw, input logic m2r);
        bus.id_valid      = 1'b1;
        bus.id_rs1        = rs1;
        bus.id_rs2        = rs2;
        bus.id_rd         = rd;
        bus.id_rs1_data   = d1;
        bus.id_rs2_data   = d2;
        bus.id_imm        = imm;
        bus.id_alu_src    = src;
        bus.id_alu_op     = op;
        bus.id_reg_write  = rw;
        bus.id_mem_read   = mr;
        bus.id_mem_write  = mw;
        bus.id_mem_to_reg = m2r;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        set_instr(5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 1'b0, ALU_AND, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.id_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;
        clear_fwd();

        #3;
        check("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
        check("rst_alu_a", bus.alu_a, 64'd0);
        check("rst_alu_op", 64'(bus.alu_op), 64'(ALU_AND));
        check("rst_bubble_cnt", 64'(bus.bubble_cnt), 64'd0);
        check("rst_ex_reg_write", 64'(bus.ex_reg_write), 64'd0);

        @(negedge clk);
        reset_n = 1'b1;

        // ADD pass-through
        set_instr(5'd1, 5'd2, 5'd5, 64'd5, 64'd7, 64'd0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("add_id_ready", 64'(bus.id_ready), 64'd1);
        step();
        check("add_ex_valid", 64'(bus.ex_valid), 64'd1);
        check("add_alu_a", bus.alu_a, 64'd5);
        check("add_alu_b", bus.alu_b, 64'd7);
        check("add_alu_op", 64'(bus.alu_op), 64'h2);
        check("add_ex_rd", 64'(bus.ex_rd), 64'd5);
        check("add_reg_write", 64'(bus.ex_reg_write), 64'd1);

        // Immediate operand; nothing new arrives behind it
        set_instr(5'd1, 5'd2, 5'd6, 64'd9, 64'd3, 64'h100, 1'b1, ALU_SUB, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("imm_alu_b", bus.alu_b, 64'h100);
        check("imm_store_data", bus.ex_store_data, 64'd3);
        bus.id_valid = 1'b0;
        step();
        check("idle_ex_valid", 64'(bus.ex_valid), 64'd0);
        check("idle_reg_write_gated", 64'(bus.ex_reg_write), 64'd0);

        // Forwarding priority on a held instruction
        set_instr(5'd3, 5'd8, 5'd9, 64'd1, 64'd2, 64'd0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        bus.id_valid = 1'b0;
        bus.ex_ready = 1'b0;
        bus.exmem_rd = 5'd3; bus.exmem_reg_write = 1'b1; bus.exmem_result = 64'h10;
        bus.memwb_rd = 5'd3; bus.memwb_reg_write = 1'b1; bus.memwb_result = 64'h20;
        #1;
        check("fwd_exmem_first", bus.alu_a, 64'h10);
        check("fwd_rs2_untouched", bus.ex_store_data, 64'd2);
        bus.exmem_reg_write = 1'b0;
        #1;
        check("fwd_memwb", bus.alu_a, 64'h20);
        bus.exmem_rd = 5'd0; bus.exmem_reg_write = 1'b1;
        bus.memwb_rd = 5'd0;
        bus.ex_ready = 1'b1;
        set_instr(5'd0, 5'd8, 5'd9, 64'h55, 64'd2, 64'd0, 1'b0, ALU_OR, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("fwd_x0_never", bus.alu_a, 64'h55);
        clear_fwd();

        // Load-use: held load to x4, consumer reads x4 as rs2
        set_instr(5'd1, 5'd2, 5'd4, 64'd0, 64'd0, 64'h8, 1'b1, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        check("ld_held", 64'(bus.ex_mem_read), 64'd1);
        set_instr(5'd7, 5'd4, 5'd0, 64'd0, 64'd0, 64'h0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("lu_id_ready_low", 64'(bus.id_ready), 64'd0);
        step();
        check("lu_bubble_ex_valid", 64'(bus.ex_valid), 64'd0);
        check("lu_bubble_mem_read", 64'(bus.ex_mem_read), 64'd0);
        check("lu_bubble_cnt", 64'(bus.bubble_cnt), 64'd1);
        check("lu_id_ready_back", 64'(bus.id_ready), 64'd1);
        bus.memwb_rd = 5'd4; bus.memwb_reg_write = 1'b1; bus.memwb_result = 64'hABCD;
        step();
        check("lu_dep_ex_valid", 64'(bus.ex_valid), 64'd1);
        check("lu_store_data", bus.ex_store_data, 64'hABCD);
        check("lu_mem_write", 64'(bus.ex_mem_write), 64'd1);
        check("lu_cnt_stable", 64'(bus.bubble_cnt), 64'd1);
        clear_fwd();

        // A load to x0 never stalls
        set_instr(5'd1, 5'd2, 5'd0, 64'd0, 64'd0, 64'd0, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        set_instr(5'd0, 5'd0, 5'd5, 64'd0, 64'd0, 64'd0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("ld_x0_no_stall", 64'(bus.id_ready), 64'd1);

        // Backpressure: A held for two stalled cycles, then B enters
        set_instr(5'd1, 5'd2, 5'd6, 64'h11, 64'h12, 64'd0, 1'b0, ALU_OR, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        bus.ex_ready = 1'b0;
        set_instr(5'd1, 5'd2, 5'd7, 64'h22, 64'h23, 64'd0, 1'b0, ALU_SUB, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("bp_id_ready_low", 64'(bus.id_ready), 64'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("bp_ex_valid", 64'(bus.ex_valid), 64'd1);
            check("bp_alu_a", bus.alu_a, 64'h11);
            check("bp_alu_b", bus.alu_b, 64'h12);
            check("bp_alu_op", 64'(bus.alu_op), 64'(ALU_OR));
            check("bp_ex_rd", 64'(bus.ex_rd), 64'd6);
        end
        bus.ex_ready = 1'b1;
        #1;
        check("bp_id_ready_high", 64'(bus.id_ready), 64'd1);
        step();
        check("bp_next_alu_a", bus.alu_a, 64'h22);
        check("bp_next_alu_op", 64'(bus.alu_op), 64'(ALU_SUB));

        // Flush with an incoming instruction
        set_instr(5'd1, 5'd2, 5'd8, 64'h33, 64'h34, 64'd0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.id_valid = 1'b0;
        check("fl_ex_valid", 64'(bus.ex_valid), 64'd0);
        check("fl_reg_write", 64'(bus.ex_reg_write), 64'd0);
        check("fl_mem_write", 64'(bus.ex_mem_write), 64'd0);

        // Asynchronous reset in the middle of a stall
        set_instr(5'd1, 5'd2, 5'd9, 64'h44, 64'h45, 64'd0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        bus.ex_ready = 1'b0;
        step();
        check("st_ex_valid", 64'(bus.ex_valid), 64'd1);
        check("st_bubble_cnt", 64'(bus.bubble_cnt), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_ex_valid", 64'(bus.ex_valid), 64'd0);
        check("ar_bubble_cnt", 64'(bus.bubble_cnt), 64'd0);
        check("ar_id_ready", 64'(bus.id_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        bus.ex_ready = 1'b1;
        set_instr(5'd1, 5'd2, 5'd10, 64'h77, 64'h78, 64'd0, 1'b0, ALU_NOR, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("post_rst_id_ready", 64'(bus.id_ready), 64'd1);
        step();
        check("post_rst_ex_valid", 64'(bus.ex_valid), 64'd1);
        check("post_rst_alu_a", bus.alu_a, 64'h77);
        check("post_rst_alu_op", 64'(bus.alu_op), 64'(ALU_NOR));

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
